rc4_phase_ctrl: RTL and testbench
=================================

# rc4_phase_ctrl

Sequencer and S-memory port owner for the RC4 decryption datapath. It runs the three RC4 phases in order: init loop (S[i]=i), key-scheduling loop (KSA) and keystream/decrypt loop (PRGA). It multiplexes the single-port 256x8 S RAM to whichever phase is active and latches the secret key for the downstream loops. It also handles the restart handshake each loop needs: loops hold their done level until they see a start pulse.

## Interface
Parameters:
- KEY_W, 24: secret key width.
- ARM_CYCLES, 2: cycles after a start pulse during which a loop's done is ignored.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to decrypt with `key`; accepted in any state.
- key  in  KEY_W  secret key, sampled when `start`=1.
- key_out  out  KEY_W  latched key driven to KSA.
- init_start, ksa_start, prga_start  out  1  one-cycle restart pulses to each loop.
- init_done, ksa_done, prga_done  in  1  loop done levels, held high until restarted.
- init_addr/ksa_addr/prga_addr  in  8  per-loop S address.
- init_data/ksa_data/prga_data  in  8  per-loop S write data.
- init_wren/ksa_wren/prga_wren  in  1  per-loop write enable.
- s_addr  out  8  S RAM address.
- s_data  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- phase  out  2  port owner: 0 INIT, 1 KSA, 2 PRGA, 3 NONE.
- busy  out  1  high in any RUN or ARM state.
- done  out  1  high in DONE until the next `start`.

## Operation
- States: INIT_RUN, READY, INIT_ARM, KSA_ARM, KSA_RUN, PRGA_ARM, PRGA_RUN, DONE.
- Reset state is INIT_RUN. The init loop self-starts from its own reset, so no `init_start` is issued here.
- INIT_RUN + init_done → READY. This sets `s_fresh`=1.
- READY / DONE + start → latch key. If `s_fresh`=1, go to KSA_ARM. Otherwise go to INIT_ARM.
- Entering any X_ARM state: `x_start` pulses for exactly the first cycle, and the arm counter loads ARM_CYCLES.
- An X_ARM state lasts ARM_CYCLES cycles, then moves to X_RUN. `x_done` is ignored throughout ARM.
- INIT_RUN + init_done → `s_fresh`=1, then KSA_ARM if a key is pending, or READY after a reset-only init.
- KSA_RUN + ksa_done → PRGA_ARM. `s_fresh` clears on entry to KSA_ARM.
- PRGA_RUN + prga_done → DONE, done=1.
- `start` while busy (abort/new key): latch the new key and go to INIT_ARM next cycle, with `s_fresh`=0. The previous owner's write is cut off that same transition.
- `start` coincident with a done: `start` wins.
- Port mux: `phase` follows the state (INIT_*→0, KSA_*→1, PRGA_*→2, READY/DONE→3).
  - `s_addr` and `s_data` pass through from the owner combinationally. They are 0 when phase=3.
  - `s_wren` = owner wren, forced 0 in ARM states and when phase=3.

## Timing
- Reset values:
  - state INIT_RUN, phase 0, busy 1, done 0.
  - all `*_start` 0, `key_out` 0, `s_fresh` 0.
- Start pulse latency: `start` sampled at edge N → `x_start`=1 during cycle N+1 only.
- RUN begins at N+1+ARM_CYCLES. The first done sample is at that edge.
- Done → next phase: `x_done` seen at edge M → next `x_start` high during cycle M+1.
- The mux has zero latency, so RAM inputs change in the same cycle as the owner's outputs.
- Mid-operation reset returns to INIT_RUN immediately and asynchronously. All outputs take their reset values.

## Structure
- Shared package `rc4_pkg`:
  - `state_t` enum, `phase_t` enum (INIT/KSA/PRGA/NONE).
  - KEY_W, ARM_CYCLES, S_DEPTH=256.
- Sub-module `s_port_mux`: a combinational 3:1 mux of addr/data/wren keyed by `phase_t`, with a wren-gate input. It is reused by the later checker block.
- The FSM, arm counter, `s_fresh` flag and key register live in `rc4_phase_ctrl`.

## Test plan
- Reset release; init_done rises at cycle 258 → READY, `s_fresh`=1, busy=0, no `init_start` ever pulsed.
- From READY, start with key=24'h000249 → `ksa_start` high one cycle and `key_out`=000249; `s_wren`=0 for 2 cycles; then phase=1 and `s_wren` follows `ksa_wren`.
- `ksa_done` still high from a previous run during KSA_ARM → ignored; no PRGA_ARM until `ksa_done` is resampled high in KSA_RUN.
- Full run then a second start with key=24'h0003FF → `init_start` pulses first (`s_fresh`=0), then KSA, then PRGA → done=1.
- start during KSA_RUN with `ksa_wren`=1 → next cycle `s_wren`=0, phase=0, `init_start` pulses, `key_out` updates.
- reset_n low mid-PRGA_RUN → outputs take their reset values asynchronously; after release, state is INIT_RUN.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 decryption datapath: sequencer states,
// S-memory port owner encoding and default sizing.
package rc4_pkg;

    localparam int KEY_W      = 24;
    localparam int ARM_CYCLES = 2;
    localparam int S_DEPTH    = 256;

    typedef enum logic [2:0] {
        ST_INIT_RUN  = 3'd0,
        ST_READY     = 3'd1,
        ST_INIT_ARM  = 3'd2,
        ST_KSA_ARM   = 3'd3,
        ST_KSA_RUN   = 3'd4,
        ST_PRGA_ARM  = 3'd5,
        ST_PRGA_RUN  = 3'd6,
        ST_DONE      = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        PH_INIT = 2'd0,
        PH_KSA  = 2'd1,
        PH_PRGA = 2'd2,
        PH_NONE = 2'd3
    } phase_t;

    function automatic phase_t phase_of(input state_t s);
        case (s)
            ST_INIT_RUN, ST_INIT_ARM: phase_of = PH_INIT;
            ST_KSA_ARM,  ST_KSA_RUN:  phase_of = PH_KSA;
            ST_PRGA_ARM, ST_PRGA_RUN: phase_of = PH_PRGA;
            default:                  phase_of = PH_NONE;
        endcase
    endfunction

    function automatic logic is_arm(input state_t s);
        is_arm = (s == ST_INIT_ARM) || (s == ST_KSA_ARM) || (s == ST_PRGA_ARM);
    endfunction

endpackage

// File: rtl/s_port_mux.sv
// Combinational 3:1 owner mux for the single-port S RAM; no owner drives zeros
// and writes can be suppressed through wren_gate.
module s_port_mux
    import rc4_pkg::*;
(
    input  phase_t     phase,
    input  logic       wren_gate,
    input  logic [7:0] init_addr,
    input  logic [7:0] init_data,
    input  logic       init_wren,
    input  logic [7:0] ksa_addr,
    input  logic [7:0] ksa_data,
    input  logic       ksa_wren,
    input  logic [7:0] prga_addr,
    input  logic [7:0] prga_data,
    input  logic       prga_wren,
    output logic [7:0] s_addr,
    output logic [7:0] s_data,
    output logic       s_wren
);

    logic owner_wren;

    always_comb begin
        s_addr     = 8'd0;
        s_data     = 8'd0;
        owner_wren = 1'b0;
        case (phase)
            PH_INIT: begin
                s_addr     = init_addr;
                s_data     = init_data;
                owner_wren = init_wren;
            end
            PH_KSA: begin
                s_addr     = ksa_addr;
                s_data     = ksa_data;
                owner_wren = ksa_wren;
            end
            PH_PRGA: begin
                s_addr     = prga_addr;
                s_data     = prga_data;
                owner_wren = prga_wren;
            end
            default: ;
        endcase
        s_wren = owner_wren & wren_gate;
    end

endmodule

// File: rtl/rc4_phase_ctrl.sv
// RC4 phase sequencer: runs init -> KSA -> PRGA, owns the S RAM port, latches
// the key and issues loop restart pulses with a done-blanking arm window.
module rc4_phase_ctrl #(
    parameter int KEY_W      = rc4_pkg::KEY_W,
    parameter int ARM_CYCLES = rc4_pkg::ARM_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] key_out,
    output logic             init_start,
    output logic             ksa_start,
    output logic             prga_start,
    input  logic             init_done,
    input  logic             ksa_done,
    input  logic             prga_done,
    input  logic [7:0]       init_addr,
    input  logic [7:0]       ksa_addr,
    input  logic [7:0]       prga_addr,
    input  logic [7:0]       init_data,
    input  logic [7:0]       ksa_data,
    input  logic [7:0]       prga_data,
    input  logic             init_wren,
    input  logic             ksa_wren,
    input  logic             prga_wren,
    output logic [7:0]       s_addr,
    output logic [7:0]       s_data,
    output logic             s_wren,
    output logic [1:0]       phase,
    output logic             busy,
    output logic             done
);

    import rc4_pkg::*;

    localparam int CNT_W = $clog2(ARM_CYCLES + 2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] arm_cnt_q;
    logic             arm_expired;
    logic             arm_load;
    logic             s_fresh_q;
    logic             key_pending_q;
    logic [KEY_W-1:0] key_q;
    logic             init_start_q, ksa_start_q, prga_start_q;
    phase_t           phase_w;

    assign arm_expired = (arm_cnt_q <= CNT_W'(1));

    // start has priority over every done; arm_load marks entry into any ARM state
    always_comb begin
        state_d  = state_q;
        arm_load = 1'b0;
        if (start) begin
            arm_load = 1'b1;
            if ((state_q == ST_READY || state_q == ST_DONE) && s_fresh_q)
                state_d = ST_KSA_ARM;
            else
                state_d = ST_INIT_ARM;
        end else begin
            case (state_q)
                ST_INIT_RUN: begin
                    if (init_done) begin
                        if (key_pending_q) begin
                            state_d  = ST_KSA_ARM;
                            arm_load = 1'b1;
                        end else begin
                            state_d = ST_READY;
                        end
                    end
                end
                ST_INIT_ARM: if (arm_expired) state_d = ST_INIT_RUN;
                ST_KSA_ARM:  if (arm_expired) state_d = ST_KSA_RUN;
                ST_PRGA_ARM: if (arm_expired) state_d = ST_PRGA_RUN;
                ST_KSA_RUN: begin
                    if (ksa_done) begin
                        state_d  = ST_PRGA_ARM;
                        arm_load = 1'b1;
                    end
                end
                ST_PRGA_RUN: if (prga_done) state_d = ST_DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_INIT_RUN;
            arm_cnt_q     <= '0;
            s_fresh_q     <= 1'b0;
            key_pending_q <= 1'b0;
            key_q         <= '0;
            init_start_q  <= 1'b0;
            ksa_start_q   <= 1'b0;
            prga_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_start_q <= arm_load && (state_d == ST_INIT_ARM);
            ksa_start_q  <= arm_load && (state_d == ST_KSA_ARM);
            prga_start_q <= arm_load && (state_d == ST_PRGA_ARM);
            if (arm_load)
                arm_cnt_q <= CNT_W'(ARM_CYCLES);
            else if (arm_cnt_q != '0)
                arm_cnt_q <= arm_cnt_q - CNT_W'(1);
            // a freshly initialised S is consumed by the next KSA; any re-arm invalidates it
            if (arm_load)
                s_fresh_q <= 1'b0;
            else if (state_q == ST_INIT_RUN && init_done)
                s_fresh_q <= 1'b1;
            if (arm_load)
                key_pending_q <= (state_d == ST_INIT_ARM);
            if (start)
                key_q <= key;
        end
    end

    assign phase_w    = phase_of(state_q);
    assign phase      = phase_w;
    assign busy       = (state_q != ST_READY) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign key_out    = key_q;
    assign init_start = init_start_q;
    assign ksa_start  = ksa_start_q;
    assign prga_start = prga_start_q;

    s_port_mux u_s_port_mux (
        .phase     (phase_w),
        .wren_gate (!is_arm(state_q)),
        .init_addr (init_addr),
        .init_data (init_data),
        .init_wren (init_wren),
        .ksa_addr  (ksa_addr),
        .ksa_data  (ksa_data),
        .ksa_wren  (ksa_wren),
        .prga_addr (prga_addr),
        .prga_data (prga_data),
        .prga_wren (prga_wren),
        .s_addr    (s_addr),
        .s_data    (s_data),
        .s_wren    (s_wren)
    );

endmodule

// File: tb/tb_rc4_phase_ctrl.sv
// Randomized bench for rc4_phase_ctrl against a loop-level reference model of
// the RC4 phase sequence, with emulated init/KSA/PRGA loops.
module tb_rc4_phase_ctrl;

    localparam int KEY_W = 24;
    localparam int ARM   = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [KEY_W-1:0] key = '0;
    logic [KEY_W-1:0] key_out;
    logic             init_start, ksa_start, prga_start;
    logic [7:0]       a_in [3];
    logic [7:0]       d_in [3];
    logic             w_in [3];
    logic             dn_in [3];
    logic [7:0]       s_addr, s_data;
    logic             s_wren;
    logic [1:0]       phase;
    logic             busy, done;

    rc4_phase_ctrl #(.KEY_W(KEY_W), .ARM_CYCLES(ARM)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key(key), .key_out(key_out),
        .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
        .init_done(dn_in[0]), .ksa_done(dn_in[1]), .prga_done(dn_in[2]),
        .init_addr(a_in[0]), .ksa_addr(a_in[1]), .prga_addr(a_in[2]),
        .init_data(d_in[0]), .ksa_data(d_in[1]), .prga_data(d_in[2]),
        .init_wren(w_in[0]), .ksa_wren(w_in[1]), .prga_wren(w_in[2]),
        .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren),
        .phase(phase), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which loop owns the port (3 = none), remaining arm cycles,
    // and which loop receives a restart pulse in the current cycle (-1 = none).
    int               m_loop, m_arm, m_pulse;
    bit               m_fresh, m_pend, m_done;
    logic [KEY_W-1:0] m_key;

    task automatic model_reset();
        m_loop = 0; m_arm = 0; m_pulse = -1;
        m_fresh = 0; m_pend = 0; m_done = 0; m_key = '0;
    endtask

    task automatic launch(input int t);
        m_loop = t; m_arm = ARM; m_pulse = t;
        m_fresh = 0; m_pend = (t == 0); m_done = 0;
    endtask

    task automatic model_step();
        m_pulse = -1;
        if (!reset_n) begin
            model_reset();
        end else if (start) begin
            m_key = key;
            launch((m_loop == 3 && m_fresh) ? 1 : 0);
        end else if (m_loop < 3 && m_arm > 0) begin
            m_arm--;
        end else if (m_loop < 3 && dn_in[m_loop]) begin
            if (m_loop == 0) begin
                m_fresh = 1;
                if (m_pend) launch(1);
                else m_loop = 3;
            end else if (m_loop == 1) begin
                launch(2);
            end else begin
                m_loop = 3;
                m_done = 1;
            end
        end
    endtask

    // Loop emulation: done drops 0-1 edges after a restart pulse, then rises after a run.
    int lg [3];
    int rn [3];
    bit env_dn [3];

    task automatic env_step(input int p);
        for (int j = 0; j < 3; j++) begin
            if (p == j) begin
                lg[j] = $urandom_range(0, 1);
                rn[j] = $urandom_range(3, 10);
                if (lg[j] == 0) env_dn[j] = 0;
            end else if (env_dn[j] && lg[j] > 0) begin
                lg[j]--;
                if (lg[j] == 0) env_dn[j] = 0;
            end else if (!env_dn[j] && rn[j] > 0) begin
                rn[j]--;
                if (rn[j] == 0) env_dn[j] = 1;
            end
        end
    endtask

    task automatic drive_random();
        for (int j = 0; j < 3; j++) begin
            a_in[j]  = 8'($urandom);
            d_in[j]  = 8'($urandom);
            w_in[j]  = 1'($urandom);
            dn_in[j] = env_dn[j];
        end
        key   = KEY_W'($urandom);
        start = 1'b0;
    endtask

    task automatic compare();
        logic [7:0] ea, ed;
        logic       ew;
        ea = 8'd0; ed = 8'd0; ew = 1'b0;
        if (m_loop < 3) begin
            ea = a_in[m_loop];
            ed = d_in[m_loop];
            ew = (m_arm == 0) ? w_in[m_loop] : 1'b0;
        end
        check("phase", phase, m_loop);
        check("busy", busy, m_loop != 3);
        check("done", done, m_done);
        check("key_out", key_out, m_key);
        check("init_start", init_start, m_pulse == 0);
        check("ksa_start", ksa_start, m_pulse == 1);
        check("prga_start", prga_start, m_pulse == 2);
        check("s_addr", s_addr, ea);
        check("s_data", s_data, ed);
        check("s_wren", s_wren, ew);
    endtask

    task automatic tick();
        int p;
        @(posedge clk);
        p = m_pulse;
        model_step();
        env_step(p);
        @(negedge clk);
        compare();
        drive_random();
    endtask

    task automatic run_to_done(input string tag, input int bound);
        for (int i = 0; i < bound && !m_done; i++) tick();
        check(tag, done, 1);
    endtask

    task automatic wait_run(input string tag, input int loop, input int bound);
        for (int i = 0; i < bound && !(m_loop == loop && m_arm == 0); i++) tick();
        check(tag, phase, loop);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_init;
        logic [KEY_W-1:0] k;
        model_reset();
        env_dn[0] = 0; rn[0] = 257; lg[0] = 0;
        env_dn[1] = 1; rn[1] = 0;   lg[1] = 0;
        env_dn[2] = 1; rn[2] = 0;   lg[2] = 0;
        drive_random();
        #1 compare();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // reset-only init run; init_start must never pulse
        n_init = 0;
        for (int i = 0; i < 400 && m_loop != 3; i++) begin
            tick();
            if (init_start) n_init++;
        end
        check("ready_busy", busy, 0);
        check("no_init_start", n_init, 0);

        // fresh S: straight to KSA
        start = 1'b1; key = 24'h000249;
        tick();
        check("ksa_start_first", ksa_start, 1);
        check("key_249", key_out, 24'h000249);
        tick();
        check("arm_wren2", s_wren, 0);
        wait_run("ksa_run1", 1, 50);
        run_to_done("done_run1", 300);

        // S consumed: re-init first
        start = 1'b1; key = 24'h0003FF;
        tick();
        check("init_start_second", init_start, 1);
        check("key_3ff", key_out, 24'h0003FF);
        run_to_done("done_run2", 300);

        // abort during KSA_RUN while KSA is writing
        start = 1'b1; key = KEY_W'($urandom);
        tick();
        wait_run("ksa_run3", 1, 200);
        k = KEY_W'($urandom);
        w_in[1] = 1'b1; start = 1'b1; key = k;
        tick();
        check("abort_wren", s_wren, 0);
        check("abort_phase", phase, 0);
        check("abort_init_start", init_start, 1);
        check("abort_key", key_out, k);
        run_to_done("done_abort", 300);

        // random restarts at arbitrary points
        for (int i = 0; i < 800; i++) begin
            tick();
            if ($urandom_range(0, 39) == 0) start = 1'b1;
        end
        run_to_done("done_random", 400);

        // asynchronous reset mid PRGA_RUN
        start = 1'b1;
        tick();
        wait_run("prga_run", 2, 300);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        env_dn[0] = 0; rn[0] = 20; lg[0] = 0;
        compare();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("post_reset_phase", phase, 0);
        check("post_reset_busy", busy, 1);
        for (int i = 0; i < 40; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
